// File: rtl/pss_sync_ctrl.sv
// rtl/pss_sync_ctrl.sv - PSS timing acquisition/tracking FSM with correlator gating
// Optional statistics counters are enabled by defining PSS_SYNC_CTRL_STATS_EN.
module pss_sync_ctrl #(
    parameter int IN_DW    = 16,
    parameter int PERIOD   = 19200,
    parameter int PSS_LEN  = 127,
    parameter int WINDOW   = 8,
    parameter int MAX_MISS = 3
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    input  logic [IN_DW-1:0]          s_axis_corr_tdata,
    input  logic                      s_axis_corr_tvalid,
    input  logic [IN_DW-1:0]          threshold_i,
    output logic                      corr_en_o,
    output logic                      peak_valid_o,
    output logic [$clog2(PERIOD)-1:0] peak_pos_o,
    output logic [IN_DW-1:0]          peak_mag_o,
    output logic                      locked_o,
    output logic [1:0]                state_o
`ifdef PSS_SYNC_CTRL_STATS_EN
    ,
    output logic [15:0]               detect_cnt_o,
    output logic [15:0]               lost_cnt_o
`endif
);

    localparam int IW   = $clog2(PERIOD);
    localparam int SPAN = 2 * WINDOW + 1;
    localparam int CW   = $clog2(SPAN + 1);
    localparam int MW   = $clog2(MAX_MISS + 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        HOLD   = 2'd1,
        WAIT   = 2'd2,
        WIN    = 2'd3
    } state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    e_pos;
    logic [MW-1:0]    misses;
    logic [CW-1:0]    cnt;
    logic [IN_DW-1:0] max_mag;
    logic [IW-1:0]    max_pos;
    logic             hit;

    function automatic int mod_sub(input int a, input int b);
        int t;
        t = a - b;
        if (t < 0) t = t + PERIOD;
        return t;
    endfunction

    logic             above;
    logic             greater;
    logic             last;
    logic             take;
    logic             span_end;
    logic             rpt;
    logic             lose;
    logic [IW-1:0]    idx_inc;
    logic [IW-1:0]    idx_n;
    logic [IW-1:0]    e_n;
    logic             locked_n;
    logic [IW-1:0]    win_start;
    logic [IW-1:0]    fin_pos;
    logic [IN_DW-1:0] fin_mag;
    logic             gate_n;

    always_comb begin
        above     = s_axis_corr_tdata > threshold_i;
        greater   = s_axis_corr_tdata > max_mag;
        last      = (cnt == CW'(SPAN - 1));
        // In WIN only above-threshold samples compete; the first hit loads unconditionally.
        take      = (state == HOLD) ? greater : (above && (!hit || greater));
        fin_pos   = take ? idx : max_pos;
        fin_mag   = take ? s_axis_corr_tdata : max_mag;
        span_end  = s_axis_corr_tvalid && last && (state == HOLD || state == WIN);
        rpt       = span_end && (state == HOLD || hit || above);
        lose      = span_end && (state == WIN) && !(hit || above)
                    && (misses == MW'(MAX_MISS - 1));
        idx_inc   = (idx == IW'(PERIOD - 1)) ? '0 : idx + 1'b1;
        idx_n     = s_axis_corr_tvalid ? idx_inc : idx;
        e_n       = rpt ? fin_pos : e_pos;
        locked_n  = rpt ? 1'b1 : (lose ? 1'b0 : locked_o);
        win_start = IW'(mod_sub(int'(e_pos), WINDOW));
        // Gate window [E-WINDOW-PSS_LEN, E+WINDOW] measured as a wrapped offset from its start.
        gate_n    = !locked_n
                    || (mod_sub(int'(idx_n), mod_sub(int'(e_n), WINDOW + PSS_LEN))
                        <= PSS_LEN + 2 * WINDOW);
    end

    assign state_o = state;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state        <= SEARCH;
            idx          <= '0;
            e_pos        <= '0;
            misses       <= '0;
            cnt          <= '0;
            max_mag      <= '0;
            max_pos      <= '0;
            hit          <= 1'b0;
            corr_en_o    <= 1'b1;
            peak_valid_o <= 1'b0;
            peak_pos_o   <= '0;
            peak_mag_o   <= '0;
            locked_o     <= 1'b0;
        end else begin
            peak_valid_o <= 1'b0;
            corr_en_o    <= gate_n;
            if (s_axis_corr_tvalid) begin
                idx <= idx_inc;
                case (state)
                    SEARCH: begin
                        if (above) begin
                            max_mag <= s_axis_corr_tdata;
                            max_pos <= idx;
                            cnt     <= CW'(1);
                            state   <= HOLD;
                        end
                    end
                    WAIT: begin
                        if (idx == win_start) begin
                            cnt   <= CW'(1);
                            hit   <= above;
                            state <= WIN;
                            if (above) begin
                                max_mag <= s_axis_corr_tdata;
                                max_pos <= idx;
                            end
                        end
                    end
                    default: begin
                        if (last) begin
                            hit <= 1'b0;
                            if (rpt) begin
                                peak_valid_o <= 1'b1;
                                peak_pos_o   <= fin_pos;
                                peak_mag_o   <= fin_mag;
                                e_pos        <= fin_pos;
                                locked_o     <= 1'b1;
                                misses       <= '0;
                                state        <= WAIT;
                            end else if (lose) begin
                                locked_o <= 1'b0;
                                misses   <= '0;
                                state    <= SEARCH;
                            end else begin
                                misses <= misses + 1'b1;
                                state  <= WAIT;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                            if (take) begin
                                max_mag <= s_axis_corr_tdata;
                                max_pos <= idx;
                            end
                            if (state == WIN && above) hit <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

`ifdef PSS_SYNC_CTRL_STATS_EN
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            detect_cnt_o <= '0;
            lost_cnt_o   <= '0;
        end else begin
            if (rpt && detect_cnt_o != 16'hFFFF) detect_cnt_o <= detect_cnt_o + 1'b1;
            if (lose && lost_cnt_o != 16'hFFFF) lost_cnt_o <= lost_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pss_sync_ctrl.sv
// tb/tb_pss_sync_ctrl.sv - scoreboard testbench for pss_sync_ctrl
module tb_pss_sync_ctrl;

    localparam int PERIOD   = 1000;
    localparam int WINDOW   = 4;
    localparam int PSS_LEN  = 127;
    localparam int MAX_MISS = 3;
    localparam int IN_DW    = 16;
    localparam int IW       = $clog2(PERIOD);

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [IN_DW-1:0] tdata = '0;
    logic             tvalid = 1'b0;
    logic [IN_DW-1:0] thr = 16'd100;
    logic             corr_en;
    logic             peak_valid;
    logic [IW-1:0]    peak_pos;
    logic [IN_DW-1:0] peak_mag;
    logic             locked;
    logic [1:0]       state;
`ifdef PSS_SYNC_CTRL_STATS_EN
    logic [15:0]      detect_cnt;
    logic [15:0]      lost_cnt;
`endif

    pss_sync_ctrl #(
        .IN_DW(IN_DW), .PERIOD(PERIOD), .PSS_LEN(PSS_LEN),
        .WINDOW(WINDOW), .MAX_MISS(MAX_MISS)
    ) dut (
        .clk_i(clk),
        .reset_ni(reset_n),
        .s_axis_corr_tdata(tdata),
        .s_axis_corr_tvalid(tvalid),
        .threshold_i(thr),
        .corr_en_o(corr_en),
        .peak_valid_o(peak_valid),
        .peak_pos_o(peak_pos),
        .peak_mag_o(peak_mag),
        .locked_o(locked),
        .state_o(state)
`ifdef PSS_SYNC_CTRL_STATS_EN
        ,
        .detect_cnt_o(detect_cnt),
        .lost_cnt_o(lost_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int pos;
        int mag;
    } rpt_t;

    rpt_t             expq[$];
    int               vectors = 0;
    int               miscompares = 0;
    int               tb_idx = 0;
    logic [IN_DW-1:0] pat [PERIOD];
    bit               gaps = 1'b0;
    bit               gate_chk = 1'b0;
    int               gate_err = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_rpt(input int pos, input int mag);
        rpt_t r;
        r.pos = pos;
        r.mag = mag;
        expq.push_back(r);
    endtask

    always @(negedge clk) begin
        rpt_t r;
        if (peak_valid) begin
            if (expq.size() == 0) begin
                check("unexpected_report", 1, 0);
            end else begin
                r = expq.pop_front();
                check("peak_pos", int'(peak_pos), r.pos);
                check("peak_mag", int'(peak_mag), r.mag);
            end
        end
    end

    task automatic step();
        if (gaps && (tb_idx % 3 == 1)) begin
            tvalid = 1'b0;
            tdata  = 16'hFFFF;
            @(posedge clk);
            #1;
        end
        if (gate_chk && (corr_en !== (tb_idx >= 71 && tb_idx <= 206))) gate_err++;
        tdata  = pat[tb_idx];
        tvalid = 1'b1;
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        tdata  = '0;
        tb_idx = (tb_idx + 1) % PERIOD;
    endtask

    task automatic run_to(input int target);
        int n;
        n = 0;
        while (tb_idx != target && n < 3 * PERIOD) begin
            step();
            n++;
        end
        if (tb_idx != target) check("run_to_bound", tb_idx, target);
    endtask

    task automatic clear_pat();
        for (int i = 0; i < PERIOD; i++) pat[i] = '0;
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        tvalid  = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_corr_en"}, int'(corr_en), 1);
        check({tag, "_state"}, int'(state), 0);
        check({tag, "_peak_valid"}, int'(peak_valid), 0);
        check({tag, "_peak_pos"}, int'(peak_pos), 0);
        check({tag, "_peak_mag"}, int'(peak_mag), 0);
        check({tag, "_locked"}, int'(locked), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tb_idx  = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_pat();
        do_reset("reset");

        // Acquisition: trigger at 200, larger peak at 202 inside the hold span
        pat[200] = 16'd500;
        pat[202] = 16'd800;
        push_rpt(202, 800);
        run_to(201);
        check("hold_state", int'(state), 1);
        run_to(209);
        check("acq_locked", int'(locked), 1);
        check("acq_state_wait", int'(state), 2);
        clear_pat();

        // Gate window over one full period, then tracking update to 203
        gate_chk = 1'b1;
        run_to(0);
        pat[203] = 16'd400;
        push_rpt(203, 400);
        run_to(200);
        check("win_state", int'(state), 3);
        run_to(207);
        gate_chk = 1'b0;
        check("corr_en_gate_errors", gate_err, 0);
        clear_pat();
        run_to(220);
        check("track_reports_done", expq.size(), 0);

        // Three silent windows around E=203 drop lock
        run_to(0);
        run_to(208);
        run_to(0);
        run_to(208);
        check("miss2_locked", int'(locked), 1);
        check("miss2_state", int'(state), 2);
        run_to(0);
        run_to(208);
        check("loss_locked", int'(locked), 0);
        check("loss_state", int'(state), 0);
        check("pos_hold", int'(peak_pos), 203);
        check("mag_hold", int'(peak_mag), 400);

        // Acquisition at 998 with a hold span wrapping past 0, then a wrapped window
        pat[998] = 16'd500;
        push_rpt(998, 500);
        run_to(7);
        check("wrap_locked", int'(locked), 1);
        pat[998] = 16'd700;
        pat[994] = 16'd150;
        pat[2]   = 16'd650;
        push_rpt(998, 700);
        run_to(3);
        clear_pat();
        run_to(20);
        check("wrap_reports_done", expq.size(), 0);

        // Tie keeps the earlier sample, in acquisition and in a gapped window
        do_reset("reset2");
        pat[200] = 16'd300;
        pat[203] = 16'd300;
        push_rpt(200, 300);
        run_to(209);
        gaps = 1'b1;
        push_rpt(200, 300);
        run_to(0);
        run_to(210);
        gaps = 1'b0;
        check("tie_reports_done", expq.size(), 0);

        // Reset in the middle of a window must not produce a report
        run_to(0);
        run_to(199);
        check("pre_abort_state", int'(state), 3);
        clear_pat();
        do_reset("abort");
        run_to(300);
        check("abort_state", int'(state), 0);
        check("final_reports_done", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
